// File: rtl/lenet_pkg.sv
// Shared types and width helpers for the LeNet response collector.
// The package is imported by the collector top and its cycle timer.
package lenet_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DIG_W_DEF = 4;

  // Width of the digit index; it must be able to hold N_RESP itself.
  function automatic int idx_w(input int n_resp);
    return $clog2(n_resp + 1);
  endfunction

  // Counter width for a terminal count of limit-1.
  // The result is never smaller than one bit.
  function automatic int cnt_w(input int limit);
    if (limit < 2) begin
      return 1;
    end else begin
      return $clog2(limit);
    end
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Clear/enable up-counter with a terminal-count flag at LIMIT-1.
// LIMIT=0 reports terminal count at all times.
module cycle_timer
  import lenet_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = cnt_w(LIMIT);
  localparam logic [CW-1:0] TC_VAL = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority over enable.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (LIMIT == 0) ? 1'b1 : (count_q == TC_VAL);

endmodule

// File: rtl/lenet_resp_collector.sv
// Launches N_RESP inferences on the LeNet core and packs the returned digits into one response word.
// The sequencer is guarded by a timeout and presents the result on a valid/ack handshake.
module lenet_resp_collector
  import lenet_pkg::*;
#(
  parameter int N_RESP      = 8,
  parameter int DIG_W       = DIG_W_DEF,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          go,
  input  logic                          ready,
  input  logic [DIG_W-1:0]              digit,
  output logic [N_RESP*DIG_W-1:0]       resp,
  output logic                          resp_valid,
  input  logic                          resp_ack,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(N_RESP+1)-1:0]   idx
);

  localparam int IDX_W  = idx_w(N_RESP);
  localparam int RESP_W = N_RESP * DIG_W;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic                terr_q, terr_d;
  logic                go_q, busy_q, valid_q;

  logic tmr_clr_s, tmr_en_s, tmr_tc_s;
  logic gap_clr_s, gap_en_s, gap_tc_s;

  cycle_timer #(.LIMIT(TIMEOUT_CYC)) u_wait_tmr (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (tmr_clr_s),
    .en_i  (tmr_en_s),
    .tc_o  (tmr_tc_s)
  );

  // The gap counter sits at zero whenever the FSM is outside GAP.
  assign gap_clr_s = (state_q != GAP);
  assign gap_en_s  = (state_q == GAP);

  cycle_timer #(.LIMIT(GAP_CYC)) u_gap_tmr (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (gap_clr_s),
    .en_i  (gap_en_s),
    .tc_o  (gap_tc_s)
  );

  // Next-state, digit capture and error logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    terr_d    = terr_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LAUNCH;
          idx_d   = '0;
          resp_d  = '0;
          terr_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        tmr_clr_s = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        tmr_en_s = 1'b1;
        // A ready on the final timeout cycle still wins over the abort.
        if (ready) begin
          for (int k = 0; k < N_RESP; k++) begin
            if (idx_q == IDX_W'(k)) begin
              resp_d[k*DIG_W +: DIG_W] = digit;
            end else begin
              resp_d[k*DIG_W +: DIG_W] = resp_q[k*DIG_W +: DIG_W];
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_RESP - 1)) begin
            state_d = DONE;
          end else if (GAP_CYC == 0) begin
            state_d = LAUNCH;
          end else begin
            state_d = GAP;
          end
        end else if (tmr_tc_s) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      GAP: begin
        if (gap_tc_s) begin
          state_d = LAUNCH;
        end else begin
          state_d = GAP;
        end
      end
      DONE: begin
        if (resp_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      resp_q  <= '0;
      terr_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      resp_q  <= resp_d;
      terr_q  <= terr_d;
      go_q    <= (state_d == LAUNCH);
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  assign go          = go_q;
  assign busy        = busy_q;
  assign resp_valid  = valid_q;
  assign timeout_err = terr_q;
  assign idx         = idx_q;
  assign resp        = resp_q;

endmodule
